param_stack: RTL and testbench
==============================

# param_stack

Parametrised LIFO stack, next generation of the 12-bit/8-entry call-return stack in the SCMIPS datapath. Adds configurable width/depth, a selectable full-stack policy (saturate or wrap-over-oldest), a same-cycle push+pop (replace-top) operation, synchronous clear, and sticky overflow/underflow flags. Sits beside the PC logic: jal pushes the return address, jr $ra pops it.

## Interface
- WIDTH, 12: entry width in bits (>=1).
- DEPTH, 8: number of entries (>=2; need not be a power of two).
- WRAP, 0: full-stack policy. 0 = saturate (drop push), 1 = wrap (overwrite oldest entry).
- clk  input  1  rising-edge clock; all state changes on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- push_sig  input  1  push push_data this cycle.
- pop_sig  input  1  discard top entry this cycle.
- clear  input  1  synchronous flush; empties stack, clears flags.
- push_data  input  WIDTH  data to push.
- pop_data  output  WIDTH  current top entry; 0 when empty.
- count  output  $clog2(DEPTH+1)  occupied entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push found the stack full.
- underflow  output  1  sticky: a pop found the stack empty.

## Operation
- Storage: DEPTH x WIDTH circular array, top pointer ptr (index of next free slot, mod DEPTH) and count register. Array contents are not reset.
- pop_data = array[(ptr-1) mod DEPTH] when count > 0, else 0; combinational from registers.
- Priority per edge: clear > push/pop decode. clear: count=0, ptr=0, overflow=0, underflow=0; push/pop ignored.
- Push only, count < DEPTH: write array[ptr], ptr = (ptr+1) mod DEPTH, count+1.
- Push only, count == DEPTH: WRAP=0 -> no write, no pointer change, overflow set. WRAP=1 -> write array[ptr] (slot of oldest entry), ptr advances, count stays DEPTH, overflow set.
- Pop only, count > 0: ptr = (ptr-1) mod DEPTH, count-1. No data movement.
- Pop only, count == 0: no change, underflow set.
- Push and pop, count > 0: replace top — write array[(ptr-1) mod DEPTH], ptr and count unchanged, no flag change (also when full, both modes).
- Push and pop, count == 0: push executes (count becomes 1), underflow set.
- Flags are sticky; only reset or clear lowers them. overflow/underflow may both be set.
- Pointer arithmetic uses explicit modular wrap (compare against DEPTH-1 / 0), never relies on natural binary overflow.

## Timing
- Reset (rst_n low, immediate, independent of clk): count=0, ptr=0, empty=1, full=0, overflow=0, underflow=0, pop_data=0. Held while rst_n low; push/pop/clear ignored.
- rst_n deasserted: first operation taken at the next rising edge.
- Latency: operation sampled at edge N; count/empty/full/pop_data/flags reflect it immediately after edge N (same cycle visible to combinational consumers). Pop result is read before the edge: pop_data in the cycle pop_sig is high is the popped value.
- Reset asserted mid-operation discards any in-flight edge; stack is empty afterwards.
- No backpressure or handshake; every request is accepted and its effect fully defined above.

## Test plan
- Saturate (WIDTH=12, DEPTH=8, WRAP=0): reset, push 0x001..0x008 -> count=8, full=1, pop_data=0x008; push 0x009 -> count=8, pop_data=0x008, overflow=1; pop 8x -> pop_data sequence 0x008..0x001, then empty=1, pop_data=0.
- Wrap (WRAP=1): push 0x001..0x009 -> count=8, overflow=1, pop_data=0x009; pop 8x -> 0x009,0x008..0x002, then empty=1, underflow=0.
- Underflow: after reset pop once -> underflow=1, count=0, pop_data=0; push 0x0AA -> count=1, pop_data=0x0AA, underflow still 1.
- Replace-top: stack holds 0x001,0x002,0x003; push+pop with 0xABC -> count=3, pop_data=0xABC; pop -> pop_data=0x002. Push+pop on empty with 0x055 -> count=1, pop_data=0x055, underflow=1.
- Clear priority: count=5, overflow=1, assert clear+push 0x123 -> count=0, empty=1, overflow=0, pop_data=0.
- Async reset: count=5, drop rst_n between clock edges -> count=0, flags 0, pop_data=0 before next edge; push during reset ignored; after release push 0x7FF -> count=1, pop_data=0x7FF.

Source files
------------

// File: rtl/param_stack.sv
// Parametrised LIFO stack with saturate/wrap full policy, replace-top, synchronous
// clear and sticky overflow/underflow flags. Storage is a circular array indexed by ptr_q.
module param_stack #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8,
  parameter bit          WRAP  = 1'b0,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_sig,
  input  logic             pop_sig,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PtrW-1:0] PtrMax  = PtrW'(DEPTH - 1);
  localparam logic [PtrW-1:0] PtrZero = '0;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic [PtrW-1:0] ptr_inc, ptr_dec;
  logic            is_empty, is_full;
  logic            mem_we;
  logic [PtrW-1:0] mem_waddr;

  // Explicit modular wrap so non-power-of-two depths behave.
  always_comb begin
    ptr_inc = (ptr_q == PtrMax) ? PtrZero : ptr_q + 1'b1;
    ptr_dec = (ptr_q == PtrZero) ? PtrMax : ptr_q - 1'b1;
  end

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CntFull);

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;

    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      unique case ({push_sig, pop_sig})
        2'b10: begin
          if (!is_full) begin
            mem_we = 1'b1;
            ptr_d  = ptr_inc;
            cnt_d  = cnt_q + CntOne;
          end else begin
            ovf_d = 1'b1;
            // Wrap mode: ptr_q already indexes the oldest entry when full.
            if (WRAP) begin
              mem_we = 1'b1;
              ptr_d  = ptr_inc;
            end
          end
        end
        2'b01: begin
          if (!is_empty) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CntOne;
          end else begin
            udf_d = 1'b1;
          end
        end
        2'b11: begin
          if (!is_empty) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_dec;
          end else begin
            mem_we = 1'b1;
            ptr_d  = ptr_inc;
            cnt_d  = CntOne;
            udf_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Gated by rst_n so a write decoded during reset cannot land in the array.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem_q[mem_waddr] <= push_data;
    end
  end

  assign pop_data  = is_empty ? '0 : mem_q[ptr_dec];
  assign count     = cnt_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench: saturate and wrap instances share stimulus; expected values are
// hand-computed per vector, plus hand-written reset sequences.
module tb_param_stack;

  logic        clk;
  logic        rst_n;
  logic        push_sig, pop_sig, clear;
  logic [11:0] push_data;

  logic [11:0] pd0, pd1;
  logic [3:0]  cnt0, cnt1;
  logic        emp0, emp1, ful0, ful1, ovf0, ovf1, udf0, udf1;

  int total = 0;
  int bad   = 0;

  param_stack #(.WIDTH(12), .DEPTH(8), .WRAP(1'b0)) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_sig (push_sig),
    .pop_sig  (pop_sig),
    .clear    (clear),
    .push_data(push_data),
    .pop_data (pd0),
    .count    (cnt0),
    .empty    (emp0),
    .full     (ful0),
    .overflow (ovf0),
    .underflow(udf0)
  );

  param_stack #(.WIDTH(12), .DEPTH(8), .WRAP(1'b1)) u_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_sig (push_sig),
    .pop_sig  (pop_sig),
    .clear    (clear),
    .push_data(push_data),
    .pop_data (pd1),
    .count    (cnt1),
    .empty    (emp1),
    .full     (ful1),
    .overflow (ovf1),
    .underflow(udf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic        pop;
    logic        clr;
    logic [11:0] data;
    int          cnt;
    logic [11:0] top0;
    logic [11:0] top1;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pu, input logic po, input logic cl, input logic [11:0] d,
                     input int c, input logic [11:0] t0, input logic [11:0] t1,
                     input logic ov, input logic ud);
    vec_t v;
    v.push = pu; v.pop = po; v.clr = cl; v.data = d;
    v.cnt = c; v.top0 = t0; v.top1 = t1; v.ovf = ov; v.udf = ud;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input int c, input logic [11:0] t0,
                           input logic [11:0] t1, input logic ov, input logic ud);
    check("sat_count", idx, 32'(cnt0), 32'(c));
    check("sat_top", idx, 32'(pd0), 32'(t0));
    check("sat_empty", idx, 32'(emp0), 32'(c == 0));
    check("sat_full", idx, 32'(ful0), 32'(c == 8));
    check("sat_ovf", idx, 32'(ovf0), 32'(ov));
    check("sat_udf", idx, 32'(udf0), 32'(ud));
    check("wrap_count", idx, 32'(cnt1), 32'(c));
    check("wrap_top", idx, 32'(pd1), 32'(t1));
    check("wrap_empty", idx, 32'(emp1), 32'(c == 0));
    check("wrap_full", idx, 32'(ful1), 32'(c == 8));
    check("wrap_ovf", idx, 32'(ovf1), 32'(ov));
    check("wrap_udf", idx, 32'(udf1), 32'(ud));
  endtask

  task automatic step(input logic pu, input logic po, input logic cl, input logic [11:0] d);
    push_sig = pu; pop_sig = po; clear = cl; push_data = d;
    @(posedge clk);
    #1;
    push_sig = 1'b0; pop_sig = 1'b0; clear = 1'b0;
  endtask

  initial begin
    // Underflow then push keeps the sticky flag.
    add(0, 1, 0, 12'h000, 0, 12'h000, 12'h000, 0, 1);
    add(1, 0, 0, 12'h0AA, 1, 12'h0AA, 12'h0AA, 0, 1);
    add(0, 0, 1, 12'h000, 0, 12'h000, 12'h000, 0, 0);
    // Fill, then one push beyond full: saturate drops it, wrap overwrites the oldest.
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 12'(i), i, 12'(i), 12'(i), 0, 0);
    add(1, 0, 0, 12'h009, 8, 12'h008, 12'h009, 1, 0);
    for (int j = 1; j <= 8; j++)
      add(0, 1, 0, 12'h000, 8 - j, 12'(8 - j), (j == 8) ? 12'h000 : 12'(9 - j), 1, 0);
    add(0, 1, 0, 12'h000, 0, 12'h000, 12'h000, 1, 1);
    add(0, 0, 1, 12'h000, 0, 12'h000, 12'h000, 0, 0);
    // Replace-top on a partially filled stack.
    for (int i = 1; i <= 3; i++) add(1, 0, 0, 12'(i), i, 12'(i), 12'(i), 0, 0);
    add(1, 1, 0, 12'hABC, 3, 12'hABC, 12'hABC, 0, 0);
    add(0, 1, 0, 12'h000, 2, 12'h002, 12'h002, 0, 0);
    add(0, 0, 1, 12'h000, 0, 12'h000, 12'h000, 0, 0);
    // Push+pop on empty: push happens and underflow sets.
    add(1, 1, 0, 12'h055, 1, 12'h055, 12'h055, 0, 1);
    add(0, 0, 1, 12'h000, 0, 12'h000, 12'h000, 0, 0);
    // Clear beats a simultaneous push.
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 12'(i), i, 12'(i), 12'(i), 0, 0);
    add(1, 0, 0, 12'h009, 8, 12'h008, 12'h009, 1, 0);
    for (int j = 1; j <= 3; j++) add(0, 1, 0, 12'h000, 8 - j, 12'(8 - j), 12'(9 - j), 1, 0);
    add(1, 0, 1, 12'h123, 0, 12'h000, 12'h000, 0, 0);
    // Replace-top while full leaves flags and count alone in both modes.
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 12'(i), i, 12'(i), 12'(i), 0, 0);
    add(1, 1, 0, 12'hABC, 8, 12'hABC, 12'hABC, 0, 0);
    add(0, 1, 0, 12'h000, 7, 12'h007, 12'h007, 0, 0);

    push_sig = 0; pop_sig = 0; clear = 0; push_data = '0;
    rst_n = 1'b0;
    #2;
    check_all(-1, 0, 12'h000, 12'h000, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].push, vecs[k].pop, vecs[k].clr, vecs[k].data);
      check_all(k, vecs[k].cnt, vecs[k].top0, vecs[k].top1, vecs[k].ovf, vecs[k].udf);
    end

    // Async reset between edges with count=5 and overflow set.
    step(0, 0, 1, 12'h000);
    for (int i = 1; i <= 9; i++) step(1, 0, 0, 12'(i));
    for (int j = 0; j < 3; j++) step(0, 1, 0, 12'h000);
    check_all(1000, 5, 12'h005, 12'h006, 1, 0);
    @(negedge clk);
    push_sig = 1'b1; push_data = 12'h1FF;
    #1 rst_n = 1'b0;
    #1;
    check_all(1001, 0, 12'h000, 12'h000, 0, 0);
    @(posedge clk);
    #1;
    check_all(1002, 0, 12'h000, 12'h000, 0, 0);
    @(negedge clk);
    push_sig = 1'b0;
    rst_n = 1'b1;
    step(1, 0, 0, 12'h7FF);
    check_all(1003, 1, 12'h7FF, 12'h7FF, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
